// File: rtl/ahb_master_pkg.sv
// ahb_master_pkg: AHB encodings, response status codes and FSM states for the command master
package ahb_master_pkg;
   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;
   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01,
      HRESP_RETRY = 2'b10,
      HRESP_SPLIT = 2'b11
   } hresp_t;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_ERROR   = 2'b01,
      ST_TIMEOUT = 2'b10,
      ST_RETRY   = 2'b11
   } rsp_status_t;
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_ADDR = 2'b01,
      S_DATA = 2'b10,
      S_RESP = 2'b11
   } state_t;
endpackage

// File: rtl/ahb_uart_cmd_master.sv
// ahb_uart_cmd_master: turns a valid/ready command stream into single-outstanding AHB SINGLE transfers
module ahb_uart_cmd_master
   import ahb_master_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int MAX_RETRY      = 4,
   parameter int CNT_W          = 9
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [2:0]  cmd_size,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_status,
   output logic [1:0]  HTRANS,
   output logic [31:0] HADDR,
   output logic        HWRITE,
   output logic [2:0]  HSIZES,
   output logic [2:0]  HBURST,
   output logic        HSELABPif,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   input  logic [1:0]  HRESP,
   input  logic [31:0] HRDATA
);
   state_t           state_q;
   htrans_t          htrans_q;
   rsp_status_t      status_q, status_nxt;
   hresp_t           resp;
   logic [CNT_W-1:0] wd_q, wd_nxt;
   logic [7:0]       rc_q, rc_nxt;
   logic [31:0]      haddr_q, hwdata_q, wdata_q, rdata_q, rdata_nxt;
   logic [2:0]       hsize_q;
   logic             hwrite_q, hsel_q, cmd_ready_q, rsp_valid_q;
   logic             timeout, retry, finish;

   // SPLIT is handled exactly like RETRY; a timeout wins over any same-cycle response
   always_comb begin
      resp       = hresp_t'(HRESP);
      wd_nxt     = wd_q + CNT_W'(!HREADY);
      rc_nxt     = rc_q + 8'd1;
      timeout    = !HREADY && (wd_nxt == CNT_W'(TIMEOUT_CYCLES));
      retry      = HREADY && (resp == HRESP_RETRY || resp == HRESP_SPLIT);
      finish     = timeout || (HREADY && (!retry || rc_nxt == 8'(MAX_RETRY)));
      status_nxt = timeout ? ST_TIMEOUT : retry ? ST_RETRY : (resp == HRESP_ERROR) ? ST_ERROR : ST_OK;
      rdata_nxt  = (status_nxt == ST_OK && !hwrite_q) ? HRDATA : 32'd0;
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= S_IDLE;
         htrans_q    <= HTRANS_IDLE;
         status_q    <= ST_OK;
         wd_q        <= '0;
         rc_q        <= '0;
         haddr_q     <= '0;
         hwdata_q    <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         hsize_q     <= '0;
         hwrite_q    <= 1'b0;
         hsel_q      <= 1'b0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_valid && cmd_ready_q) begin
                  state_q     <= S_ADDR;
                  cmd_ready_q <= 1'b0;
                  htrans_q    <= HTRANS_NONSEQ;
                  hsel_q      <= 1'b1;
                  haddr_q     <= cmd_addr;
                  hwrite_q    <= cmd_write;
                  hsize_q     <= cmd_size;
                  wdata_q     <= cmd_wdata;
                  rc_q        <= '0;
                  wd_q        <= '0;
               end
            end
            S_ADDR: begin
               if (HREADY) begin
                  state_q  <= S_DATA;
                  htrans_q <= HTRANS_IDLE;
                  hwdata_q <= wdata_q;
               end
            end
            S_DATA: begin
               wd_q <= wd_nxt;
               if (finish) begin
                  state_q     <= S_RESP;
                  hsel_q      <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  status_q    <= status_nxt;
                  rdata_q     <= rdata_nxt;
               end else if (retry) begin
                  state_q  <= S_ADDR;
                  htrans_q <= HTRANS_NONSEQ;
                  rc_q     <= rc_nxt;
                  wd_q     <= '0;
               end
            end
            default: begin
               if (rsp_ready) begin
                  state_q     <= S_IDLE;
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
               end
            end
         endcase
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rdata_q;
   assign rsp_status = status_q;
   assign HTRANS     = htrans_q;
   assign HADDR      = haddr_q;
   assign HWRITE     = hwrite_q;
   assign HSIZES     = hsize_q;
   assign HBURST     = HBURST_SINGLE;
   assign HSELABPif  = hsel_q;
   assign HWDATA     = hwdata_q;
endmodule

// File: tb/tb_ahb_uart_cmd_master.sv
// tb_ahb_uart_cmd_master: directed bench; the bench plays the AHB slave and drives/samples on the falling edge
module tb_ahb_uart_cmd_master;
   logic        HCLK = 1'b0, HRESET = 1'b1;
   logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
   logic [31:0] cmd_addr = '0, cmd_wdata = '0, HRDATA = '0;
   logic [2:0]  cmd_size = '0;
   logic        HREADY = 1'b1;
   logic [1:0]  HRESP = 2'b00;
   logic        cmd_ready, rsp_valid, HWRITE, HSELABPif;
   logic [31:0] rsp_rdata, HADDR, HWDATA;
   logic [1:0]  rsp_status, HTRANS;
   logic [2:0]  HSIZES, HBURST;
   int          n_cmp = 0, n_bad = 0;

   ahb_uart_cmd_master #(.TIMEOUT_CYCLES(16), .MAX_RETRY(4), .CNT_W(9)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
      .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZES(HSIZES), .HBURST(HBURST),
      .HSELABPif(HSELABPif), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge HCLK);
   endtask

   // returns on the falling edge of the ADDR cycle
   task automatic send(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
      int i = 0;
      while (cmd_ready !== 1'b1 && i < 20) begin
         step();
         i++;
      end
      chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic take_rsp(input string tag, input logic [1:0] st, input logic [31:0] rd);
      int i = 0;
      while (rsp_valid !== 1'b1 && i < 40) begin
         step();
         i++;
      end
      chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_status"}, {30'd0, rsp_status}, {30'd0, st});
      chk({tag, "_rdata"}, rsp_rdata, rd);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk({tag, "_drop"}, {31'd0, rsp_valid}, 32'd0);
   endtask

   // answers every data phase with RETRY for the first nret tries, OKAY afterwards
   task automatic retry_run(input int nret, output int nonseq);
      int n = 0;
      nonseq = 0;
      for (int c = 0; c < 60 && rsp_valid !== 1'b1; c++) begin
         if (HTRANS == 2'b10) begin
            nonseq++;
            HREADY = 1'b1; HRESP = 2'b00;
         end else if (HSELABPif) begin
            HREADY = 1'b1;
            HRESP  = (n < nret) ? 2'b10 : 2'b00;
            n++;
         end
         step();
      end
      HRESP = 2'b00;
   endtask

   initial begin
      int ns, bad;
      step(); step();
      chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
      chk("rst_hsel", {31'd0, HSELABPif}, 32'd0);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("hburst", {29'd0, HBURST}, 32'd0);
      HRESET = 1'b0;
      step();
      chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

      send(1'b1, 32'h4, 3'b000, 32'h55);
      chk("w_htrans_addr", {30'd0, HTRANS}, 32'h2);
      chk("w_haddr", HADDR, 32'h4);
      chk("w_hwrite", {31'd0, HWRITE}, 32'd1);
      chk("w_hsize", {29'd0, HSIZES}, 32'd0);
      chk("w_hsel", {31'd0, HSELABPif}, 32'd1);
      chk("w_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      step();
      chk("w_htrans_data", {30'd0, HTRANS}, 32'd0);
      chk("w_hwdata", HWDATA, 32'h55);
      chk("w_rsp_early", {31'd0, rsp_valid}, 32'd0);
      step();
      chk("w_rsp_latency", {31'd0, rsp_valid}, 32'd1);
      take_rsp("w", 2'b00, 32'd0);
      chk("w_back_idle", {31'd0, cmd_ready}, 32'd1);

      send(1'b0, 32'h8, 3'b010, 32'h0);
      chk("r_hwrite", {31'd0, HWRITE}, 32'd0);
      step();
      HREADY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("r_haddr_stable", HADDR, 32'h8);
         chk("r_wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      HREADY = 1'b1; HRDATA = 32'hA5;
      step();
      take_rsp("r", 2'b00, 32'hA5);

      send(1'b1, 32'hC, 3'b010, 32'h11);
      step();
      HREADY = 1'b0; HRESP = 2'b01;
      step();
      chk("e_first_cycle", {31'd0, rsp_valid}, 32'd0);
      HREADY = 1'b1;
      step();
      HRESP = 2'b00;
      take_rsp("e", 2'b01, 32'd0);
      chk("e_idle", {31'd0, cmd_ready}, 32'd1);
      send(1'b1, 32'h10, 3'b000, 32'h22);
      take_rsp("e_next", 2'b00, 32'd0);

      HRDATA = 32'h3C;
      send(1'b0, 32'h20, 3'b010, 32'h0);
      retry_run(2, ns);
      chk("rt2_nonseq", ns, 32'd3);
      take_rsp("rt2", 2'b00, 32'h3C);
      send(1'b0, 32'h24, 3'b010, 32'h0);
      retry_run(99, ns);
      chk("rt4_nonseq", ns, 32'd4);
      take_rsp("rt4", 2'b11, 32'd0);

      send(1'b0, 32'h30, 3'b010, 32'h0);
      step();
      HREADY = 1'b0;
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (HSELABPif !== 1'b1 || rsp_valid !== 1'b0) bad++;
      end
      chk("to_wait_held", bad, 32'd0);
      step();
      chk("to_hsel_drop", {31'd0, HSELABPif}, 32'd0);
      chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      HREADY = 1'b1; HRDATA = 32'hFF;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("to_hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("to_hold_status", {30'd0, rsp_status}, 32'h2);
         chk("to_hold_rdata", rsp_rdata, 32'd0);
         chk("to_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      end
      take_rsp("to", 2'b10, 32'd0);

      send(1'b0, 32'h40, 3'b010, 32'h0);
      step();
      HREADY = 1'b0;
      step();
      HRESET = 1'b1;
      step();
      HRESET = 1'b0; HREADY = 1'b1;
      chk("mr_htrans", {30'd0, HTRANS}, 32'd0);
      chk("mr_hsel", {31'd0, HSELABPif}, 32'd0);
      chk("mr_haddr", HADDR, 32'd0);
      chk("mr_hwdata", HWDATA, 32'd0);
      chk("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("mr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("mr_rsp_status", {30'd0, rsp_status}, 32'd0);
      step();
      chk("mr_no_rsp", {31'd0, rsp_valid}, 32'd0);
      send(1'b1, 32'h44, 3'b000, 32'h77);
      take_rsp("mr_after", 2'b00, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
